fifo_pkt_reader: RTL and testbench
==================================

# fifo_pkt_reader

Packet-aware drain stage directly downstream of the first-word-fallthrough small FIFO. It pops 72-bit entries (control byte plus 64-bit data word) whenever the FIFO is non-empty and the next stage has room, and presents them on the standard out_data/out_ctrl/out_wr/out_rdy bus one cycle later. It tracks packet boundaries from the control byte, discards stray payload words that arrive outside a packet, and keeps packet, word and drop statistics. The enable input takes effect only between packets.

## Interface
- DATA_WIDTH, 64, data bits per FIFO entry
- CTRL_WIDTH, DATA_WIDTH/8, control bits per entry; FIFO entry is {ctrl, data}, ctrl in the MSBs
- CNT_WIDTH, 32, width of pkt_count and drop_count
- WORD_CNT_WIDTH, 16, width of word counters
---
- clk  in  1  single clock, all logic rising-edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  allow new packets to start; sampled only in IDLE
- fifo_dout  in  DATA_WIDTH+CTRL_WIDTH  FIFO head entry, valid while fifo_empty=0
- fifo_empty  in  1  FIFO empty
- fifo_rd_en  out  1  pop FIFO head this cycle (combinational)
- out_data  out  DATA_WIDTH  forwarded data (registered)
- out_ctrl  out  CTRL_WIDTH  forwarded control (registered)
- out_wr  out  1  out_data/out_ctrl valid this cycle (registered)
- out_rdy  in  1  downstream can take one more word next cycle
- in_packet  out  1  high from header accept until EOP accept
- pkt_count  out  CNT_WIDTH  completed packets, wraps
- drop_count  out  CNT_WIDTH  discarded stray words, wraps
- last_pkt_words  out  WORD_CNT_WIDTH  word count of the last completed packet
- err_stray  out  1  one-cycle pulse per discarded word

## Operation
- Word class from ctrl = fifo_dout[top CTRL_WIDTH bits]: ctrl≠0 is a header/EOP word; ctrl=0 is a payload word.
- States:
  - IDLE: waiting for a packet start.
  - HDR: header words (ctrl≠0) are flowing.
  - PAYLOAD: payload words (ctrl=0) are flowing.
- Pop condition, evaluated combinationally each cycle ("pop"):
  - fifo_rd_en = ~fifo_empty & (fwd ? out_rdy : 1'b1)
  - fwd = 0 only in IDLE for ctrl=0 (stray word). Strays are discarded without waiting on out_rdy.
  - In IDLE with enable=0, fifo_rd_en=0.
- Transitions (all on a pop):
  - IDLE, ctrl≠0: go to HDR; word_cnt←1.
  - IDLE, ctrl=0: stay in IDLE; drop the word; drop_count+1; err_stray pulse.
  - HDR, ctrl≠0: stay in HDR; word_cnt+1.
  - HDR, ctrl=0: go to PAYLOAD; word_cnt+1.
  - PAYLOAD, ctrl=0: stay in PAYLOAD; word_cnt+1.
  - PAYLOAD, ctrl≠0 (EOP): go to IDLE; pkt_count+1; last_pkt_words←word_cnt+1.
- Without a pop, state and counters hold.
- enable low: any packet in progress completes normally. No new header is accepted until enable returns high.
- word_cnt saturates at all-ones; no wrap. pkt_count and drop_count wrap modulo 2^CNT_WIDTH.
- in_packet = (state≠IDLE), registered.

## Timing
- Forwarded words: entry popped in cycle N appears on out_data/out_ctrl with out_wr=1 in cycle N+1. Latency is 1 cycle; throughput is 1 word/cycle while out_rdy=1 and the FIFO is non-empty.
- out_wr=0 in any cycle following a non-forwarding cycle. out_data/out_ctrl hold their last value when out_wr=0.
- out_rdy deassert: fifo_rd_en drops in the same cycle. At most the one already-registered word is issued after out_rdy falls.
- err_stray pulses in the cycle after the discarding pop; drop_count updates in that same cycle.
- Counters and state update on the clock edge ending the pop cycle.
- Reset (asynchronous assert, any cycle, including mid-packet), all of the following immediately:
  - state=IDLE
  - out_wr=0, out_data=0, out_ctrl=0
  - in_packet=0, err_stray=0
  - pkt_count=0, drop_count=0, last_pkt_words=0, word_cnt=0
- fifo_rd_en is 0 while reset_n=0. A partial packet in flight at reset is abandoned, not counted.
- Reset release is synchronized by the integrator; the block's first pop can occur on the first edge after release.

## Test plan
- Single packet: headers ctrl=0xFF,0xFF, payloads ctrl=0 ×3, EOP ctrl=0x0F; out_rdy=1 → 6 consecutive out_wr cycles, each 1 cycle after its pop; pkt_count=1; last_pkt_words=6; in_packet high exactly 6 cycles.
- Backpressure: same packet with out_rdy toggling 1,0,0,1,… → fifo_rd_en=0 on every out_rdy=0 cycle; output order and values unchanged; pkt_count=1.
- Stray words: FIFO holds ctrl=0 ×2, then a valid 3-word packet; out_rdy=0 → both strays popped and dropped anyway; drop_count=2; two err_stray pulses; no out_wr for the strays; packet waits for out_rdy.
- Enable gating: enable falls mid-payload → packet completes, pkt_count+1; next header stays in the FIFO (fifo_rd_en=0) until enable=1.
- Async reset mid-packet: reset_n low after 2 words → immediate out_wr=0, all counters 0, IDLE; after release, a new packet counts pkt_count=1.
- Counter wrap: force pkt_count to all-ones and complete one packet → pkt_count=0; a 70000-word packet → last_pkt_words=0xFFFF (saturated).

Source files
------------

// File: rtl/fifo_pkt_reader.sv
// Packet-aware drain stage behind a first-word-fallthrough FIFO: forwards packet words with one
// cycle of latency, discards stray payload words seen between packets, and keeps packet statistics.
module fifo_pkt_reader #(
    parameter int DATA_WIDTH     = 64,
    parameter int CTRL_WIDTH     = DATA_WIDTH / 8,
    parameter int CNT_WIDTH      = 32,
    parameter int WORD_CNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic [DATA_WIDTH+CTRL_WIDTH-1:0] fifo_dout,
    input  logic                           fifo_empty,
    output logic                           fifo_rd_en,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [CTRL_WIDTH-1:0]          out_ctrl,
    output logic                           out_wr,
    input  logic                           out_rdy,
    output logic                           in_packet,
    output logic [CNT_WIDTH-1:0]           pkt_count,
    output logic [CNT_WIDTH-1:0]           drop_count,
    output logic [WORD_CNT_WIDTH-1:0]      last_pkt_words,
    output logic                           err_stray
);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD} state_t;

    state_t state_q, state_d;

    logic [CTRL_WIDTH-1:0]     head_ctrl;
    logic                      head_is_ctrl;
    logic                      idle;
    logic                      fwd;
    logic                      pop;
    logic                      fwd_pop;
    logic                      stray_pop;
    logic                      eop_pop;

    logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;
    logic [CTRL_WIDTH-1:0]     out_ctrl_q, out_ctrl_d;
    logic                      out_wr_q, out_wr_d;
    logic                      in_packet_q, in_packet_d;
    logic                      err_stray_q, err_stray_d;
    logic [CNT_WIDTH-1:0]      pkt_count_q, pkt_count_d;
    logic [CNT_WIDTH-1:0]      drop_count_q, drop_count_d;
    logic [WORD_CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [WORD_CNT_WIDTH-1:0] word_cnt_inc;
    logic [WORD_CNT_WIDTH-1:0] last_words_q, last_words_d;

    assign head_ctrl    = fifo_dout[DATA_WIDTH +: CTRL_WIDTH];
    assign head_is_ctrl = |head_ctrl;
    assign idle         = (state_q == S_IDLE);

    // State register
    // NOTE: every flop uses non-blocking assignment so all registers sample the same pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (pop) begin
            case (state_q)
                S_IDLE:    if (head_is_ctrl)  state_d = S_HDR;
                S_HDR:     if (!head_is_ctrl) state_d = S_PAYLOAD;
                S_PAYLOAD: if (head_is_ctrl)  state_d = S_IDLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Output / pop decode: strays between packets are dropped without waiting for out_rdy
    always_comb begin
        fwd       = !(idle && !head_is_ctrl);
        pop       = reset_n && !fifo_empty && (!idle || enable) && (fwd ? out_rdy : 1'b1);
        fwd_pop   = pop && fwd;
        stray_pop = pop && !fwd;
        eop_pop   = pop && (state_q == S_PAYLOAD) && head_is_ctrl;
    end

    assign fifo_rd_en = pop;

    always_comb begin
        word_cnt_inc = (&word_cnt_q) ? word_cnt_q : word_cnt_q + WORD_CNT_WIDTH'(1);

        out_data_d   = fwd_pop ? fifo_dout[DATA_WIDTH-1:0] : out_data_q;
        out_ctrl_d   = fwd_pop ? head_ctrl : out_ctrl_q;
        out_wr_d     = fwd_pop;
        err_stray_d  = stray_pop;
        // Stays high through the cycle the EOP word is presented on the output
        in_packet_d  = (state_d != S_IDLE) || eop_pop;

        word_cnt_d   = word_cnt_q;
        if (fwd_pop) word_cnt_d = idle ? WORD_CNT_WIDTH'(1) : word_cnt_inc;

        last_words_d = eop_pop ? word_cnt_inc : last_words_q;
        pkt_count_d  = eop_pop ? pkt_count_q + CNT_WIDTH'(1) : pkt_count_q;
        drop_count_d = stray_pop ? drop_count_q + CNT_WIDTH'(1) : drop_count_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q   <= '0;
            out_ctrl_q   <= '0;
            out_wr_q     <= 1'b0;
            in_packet_q  <= 1'b0;
            err_stray_q  <= 1'b0;
            pkt_count_q  <= '0;
            drop_count_q <= '0;
            word_cnt_q   <= '0;
            last_words_q <= '0;
        end else begin
            out_data_q   <= out_data_d;
            out_ctrl_q   <= out_ctrl_d;
            out_wr_q     <= out_wr_d;
            in_packet_q  <= in_packet_d;
            err_stray_q  <= err_stray_d;
            pkt_count_q  <= pkt_count_d;
            drop_count_q <= drop_count_d;
            word_cnt_q   <= word_cnt_d;
            last_words_q <= last_words_d;
        end
    end

    assign out_data       = out_data_q;
    assign out_ctrl       = out_ctrl_q;
    assign out_wr         = out_wr_q;
    assign in_packet      = in_packet_q;
    assign err_stray      = err_stray_q;
    assign pkt_count      = pkt_count_q;
    assign drop_count     = drop_count_q;
    assign last_pkt_words = last_words_q;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Bench for fifo_pkt_reader: a queue-backed FWFT FIFO feeds two instances (default widths and
// narrow counters) and a packet-level reference model predicts every pop and output.
module tb_fifo_pkt_reader;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int EW = DW + CW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          out_rdy;
    logic          fifo_empty;
    logic [EW-1:0] fifo_dout;

    logic          fifo_rd_en, out_wr, in_packet, err_stray;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [31:0]   pkt_count, drop_count;
    logic [15:0]   last_pkt_words;

    logic          fifo_rd_en_s, out_wr_s, in_packet_s, err_stray_s;
    logic [DW-1:0] out_data_s;
    logic [CW-1:0] out_ctrl_s;
    logic [2:0]    pkt_count_s, drop_count_s;
    logic [3:0]    last_pkt_words_s;

    fifo_pkt_reader dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .in_packet(in_packet), .pkt_count(pkt_count), .drop_count(drop_count),
        .last_pkt_words(last_pkt_words), .err_stray(err_stray)
    );

    fifo_pkt_reader #(.CNT_WIDTH(3), .WORD_CNT_WIDTH(4)) dut_s (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en_s),
        .out_data(out_data_s), .out_ctrl(out_ctrl_s), .out_wr(out_wr_s), .out_rdy(out_rdy),
        .in_packet(in_packet_s), .pkt_count(pkt_count_s), .drop_count(drop_count_s),
        .last_pkt_words(last_pkt_words_s), .err_stray(err_stray_s)
    );

    always #5 clk = ~clk;

    // Reference model: packet-level view of the word stream
    logic [EW-1:0] fifo_q[$];
    bit            m_in_pkt, m_seen_pay;
    longint        m_words, m_last, m_pkts, m_drops;
    bit            exp_wr, exp_err, exp_inp;
    logic [DW-1:0] exp_data;
    logic [CW-1:0] exp_ctrl;

    int checks = 0, failures = 0;
    int n_wr, n_inp, n_err;

    function automatic longint sat(input longint v, input longint lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic push(input logic [CW-1:0] c);
        fifo_q.push_back({c, $urandom(), $urandom()});
    endtask

    task automatic model_reset();
        m_in_pkt = 0; m_seen_pay = 0;
        m_words = 0; m_last = 0; m_pkts = 0; m_drops = 0;
        exp_wr = 0; exp_err = 0; exp_inp = 0;
        exp_data = '0; exp_ctrl = '0;
        fifo_q.delete();
    endtask

    // One clock: entered and left at a falling edge; caller sets enable/out_rdy beforehand
    task automatic cycle();
        logic [95:0]   rnd;
        logic [EW-1:0] word;
        logic [CW-1:0] c;
        bit            exp_rd, eop;
        rnd        = {$urandom(), $urandom(), $urandom()};
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = fifo_empty ? rnd[EW-1:0] : fifo_q[0];
        #1;
        c      = fifo_dout[EW-1:DW];
        exp_rd = reset_n && !fifo_empty && (m_in_pkt || enable) &&
                 ((!m_in_pkt && c == 0) || out_rdy);
        chk("fifo_rd_en", 64'(fifo_rd_en), 64'(exp_rd));
        chk("fifo_rd_en_s", 64'(fifo_rd_en_s), 64'(exp_rd));
        @(posedge clk);
        exp_wr = 0; exp_err = 0; eop = 0;
        if (exp_rd) begin
            word = fifo_q.pop_front();
            c    = word[EW-1:DW];
            if (!m_in_pkt && c == 0) begin
                m_drops++;
                exp_err = 1;
            end else begin
                exp_wr   = 1;
                exp_data = word[DW-1:0];
                exp_ctrl = c;
                if (!m_in_pkt) begin
                    m_in_pkt = 1; m_seen_pay = 0; m_words = 1;
                end else begin
                    m_words++;
                    if (c == 0) m_seen_pay = 1;
                    else if (m_seen_pay) begin
                        m_pkts++; m_last = m_words; m_in_pkt = 0; eop = 1;
                    end
                end
            end
        end
        exp_inp = m_in_pkt || eop;
        @(negedge clk);
        chk("out_wr", 64'(out_wr), 64'(exp_wr));
        chk("err_stray", 64'(err_stray), 64'(exp_err));
        chk("in_packet", 64'(in_packet), 64'(exp_inp));
        chk("out_data", out_data, exp_data);
        chk("out_ctrl", 64'(out_ctrl), 64'(exp_ctrl));
        chk("pkt_count", 64'(pkt_count), 64'(m_pkts % 64'h1_0000_0000));
        chk("drop_count", 64'(drop_count), 64'(m_drops % 64'h1_0000_0000));
        chk("last_pkt_words", 64'(last_pkt_words), 64'(sat(m_last, 65535)));
        chk("out_wr_s", 64'(out_wr_s), 64'(exp_wr));
        chk("err_stray_s", 64'(err_stray_s), 64'(exp_err));
        chk("in_packet_s", 64'(in_packet_s), 64'(exp_inp));
        chk("out_data_s", out_data_s, exp_data);
        chk("out_ctrl_s", 64'(out_ctrl_s), 64'(exp_ctrl));
        chk("pkt_count_s", 64'(pkt_count_s), 64'(m_pkts % 8));
        chk("drop_count_s", 64'(drop_count_s), 64'(m_drops % 8));
        chk("last_pkt_words_s", 64'(last_pkt_words_s), 64'(sat(m_last, 15)));
        if (out_wr)    n_wr++;
        if (in_packet) n_inp++;
        if (err_stray) n_err++;
    endtask

    // Asynchronous assertion mid-cycle, released at a falling edge
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_out_wr", 64'(out_wr), 64'(0));
        chk("rst_out_data", out_data, 64'(0));
        chk("rst_out_ctrl", 64'(out_ctrl), 64'(0));
        chk("rst_in_packet", 64'(in_packet), 64'(0));
        chk("rst_err_stray", 64'(err_stray), 64'(0));
        chk("rst_pkt_count", 64'(pkt_count), 64'(0));
        chk("rst_drop_count", 64'(drop_count), 64'(0));
        chk("rst_last_words", 64'(last_pkt_words), 64'(0));
        chk("rst_fifo_rd_en", 64'(fifo_rd_en), 64'(0));
        chk("rst_pkt_count_s", 64'(pkt_count_s), 64'(0));
        model_reset();
        @(negedge clk);
        chk("rst_fifo_rd_en_hold", 64'(fifo_rd_en), 64'(0));
        reset_n = 1'b1;
    endtask

    task automatic drain(input int max_cycles, input int rdy_pct, input int en_pct);
        int n = 0;
        while (fifo_q.size() != 0 && n < max_cycles) begin
            out_rdy = ($urandom_range(99) < rdy_pct);
            enable  = ($urandom_range(99) < en_pct);
            cycle();
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b1; enable = 1'b0; out_rdy = 1'b0;
        fifo_empty = 1'b1; fifo_dout = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single packet at full rate
        enable = 1'b1; out_rdy = 1'b1;
        push(8'hFF); push(8'hFF); push(8'h00); push(8'h00); push(8'h00); push(8'h0F);
        n_wr = 0; n_inp = 0;
        repeat (8) cycle();
        chk("single_out_wr_cycles", 64'(n_wr), 64'(6));
        chk("single_in_packet_cycles", 64'(n_inp), 64'(6));
        chk("single_pkt_count", 64'(pkt_count), 64'(1));
        chk("single_last_words", 64'(last_pkt_words), 64'(6));

        // Backpressure: out_rdy 1,0,0,1,0,0,...
        push(8'hFF); push(8'hFF); push(8'h00); push(8'h00); push(8'h00); push(8'h0F);
        n_wr = 0;
        for (int i = 0; i < 20; i++) begin
            out_rdy = (i % 3 == 0);
            cycle();
        end
        chk("bp_out_wr_cycles", 64'(n_wr), 64'(6));
        chk("bp_pkt_count", 64'(pkt_count), 64'(2));

        // Strays are dropped even with out_rdy low; the packet behind them waits
        push(8'h00); push(8'h00); push(8'h01); push(8'h00); push(8'h80);
        out_rdy = 1'b0; n_err = 0; n_wr = 0;
        repeat (5) cycle();
        chk("stray_err_pulses", 64'(n_err), 64'(2));
        chk("stray_drop_count", 64'(drop_count), 64'(2));
        chk("stray_no_out_wr", 64'(n_wr), 64'(0));
        out_rdy = 1'b1;
        repeat (5) cycle();
        chk("stray_pkt_count", 64'(pkt_count), 64'(3));
        chk("stray_pkt_out_wr", 64'(n_wr), 64'(3));

        // Enable dropped mid-payload: packet finishes, next header is held
        push(8'h11); push(8'h00); push(8'h00);
        repeat (3) cycle();
        enable = 1'b0;
        push(8'h00); push(8'h22); push(8'h33); push(8'h00); push(8'h44);
        n_wr = 0;
        repeat (8) cycle();
        chk("en_pkt_completes", 64'(pkt_count), 64'(4));
        chk("en_header_held", 64'(n_wr), 64'(2));
        enable = 1'b1;
        repeat (5) cycle();
        chk("en_next_pkt", 64'(pkt_count), 64'(5));

        // Random packets with strays, random out_rdy and enable
        for (int p = 0; p < 40; p++) begin
            repeat ($urandom_range(2)) push(8'h00);
            repeat ($urandom_range(1, 2)) push(8'($urandom_range(1, 255)));
            repeat ($urandom_range(1, 4)) push(8'h00);
            push(8'($urandom_range(1, 255)));
            drain(300, 70, 85);
        end
        enable = 1'b1; out_rdy = 1'b1;
        repeat (3) cycle();

        // Long packet: narrow instance saturates its word count
        push(8'h01);
        repeat (18) push(8'h00);
        push(8'h02);
        repeat (22) cycle();
        chk("long_last_words", 64'(last_pkt_words), 64'(20));
        chk("long_last_words_sat", 64'(last_pkt_words_s), 64'(15));

        // Reset after two words of a packet; a fresh packet then counts from zero
        push(8'hFF); push(8'hFF); push(8'h00); push(8'h00); push(8'h00); push(8'h0F);
        repeat (2) cycle();
        do_reset();
        push(8'hFF); push(8'hFF); push(8'h00); push(8'h00); push(8'h00); push(8'h0F);
        repeat (8) cycle();
        chk("post_rst_pkt_count", 64'(pkt_count), 64'(1));
        chk("post_rst_last_words", 64'(last_pkt_words), 64'(6));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
